seq_divider16: RTL

Sequential 16-by-8 unsigned restoring divider, the inverse of the team's 8x8 combinational multiplier. It accepts a 16-bit dividend and an 8-bit divisor on a start pulse, resolves one quotient bit per clock, and returns a 16-bit quotient and an 8-bit remainder with a done pulse. For divisor d != 0, any 16-bit product p = a*d from the multiplier divides back to exactly a, remainder 0.

---
 rtl/seq_divider16_if.sv | 21 ++
 rtl/seq_divider16.sv | 126 ++++++++++++
 2 files changed

// File: rtl/seq_divider16_if.sv
// Handshake and result bundle for the 16-by-8 sequential divider.
interface seq_divider16_if;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/seq_divider16.sv
// Sequential 16-by-8 unsigned restoring divider, one quotient bit per clock.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor completes in one cycle and flags div_zero.
module seq_divider16 (
    input  logic              clk,
    input  logic              rst,
    seq_divider16_if.slave    bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
`ifdef DIV_ZERO_FAST_EN
    localparam logic [1:0] DZ   = 2'd2;
`endif

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic        busy_r;
    logic        done_r;
    logic [15:0] quotient_r;
    logic [7:0]  remainder_r;

    logic [15:0] dvd_sh;
    logic [7:0]  dvs;
    logic [7:0]  p;
    logic [15:0] q_sh;

    logic [8:0]  t;
    logic        ge;
    logic [7:0]  p_next;
    logic [15:0] q_next;
    logic        accept;

    assign accept = (state == IDLE) && bus.start;

    // Restoring step: the 9-bit trial value never overflows, and the
    // restored/subtracted result is always below the divisor, so 8 bits hold it.
    always_comb begin
        t      = {p, dvd_sh[15]};
        ge     = (t >= {1'b0, dvs});
        p_next = ge ? 8'(t - {1'b0, dvs}) : t[7:0];
        q_next = {q_sh[14:0], ge};
    end

    // Working registers carry no reset; they are always loaded on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            dvd_sh <= bus.dividend;
            dvs    <= bus.divisor;
            p      <= 8'h00;
            q_sh   <= 16'h0000;
        end else if (state == RUN) begin
            dvd_sh <= {dvd_sh[14:0], 1'b0};
            p      <= p_next;
            q_sh   <= q_next;
        end
    end

`ifdef DIV_ZERO_FAST_EN
    logic div_zero_r;
    assign bus.div_zero = div_zero_r;
`else
    assign bus.div_zero = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 5'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= 16'h0000;
            remainder_r <= 8'h00;
`ifdef DIV_ZERO_FAST_EN
            div_zero_r  <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_r <= 1'b1;
                        cnt    <= 5'd15;
`ifdef DIV_ZERO_FAST_EN
                        state  <= (bus.divisor == 8'h00) ? DZ : RUN;
`else
                        state  <= RUN;
`endif
                    end
                end
                RUN: begin
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd0) begin
                        quotient_r  <= q_next;
                        remainder_r <= p_next;
                        done_r      <= 1'b1;
                        busy_r      <= 1'b0;
                        state       <= IDLE;
`ifdef DIV_ZERO_FAST_EN
                        div_zero_r  <= 1'b0;
`endif
                    end
                end
`ifdef DIV_ZERO_FAST_EN
                DZ: begin
                    quotient_r  <= 16'hFFFF;
                    remainder_r <= dvd_sh[7:0];
                    div_zero_r  <= 1'b1;
                    done_r      <= 1'b1;
                    busy_r      <= 1'b0;
                    state       <= IDLE;
                end
`endif
                default: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;

endmodule
